mac_seq_ctrl: RTL

Sequencing controller for the bit-serial three-lane MAC. It walks a dot product of `n_groups` operand triplets through one MAC instance: it fetches each triplet from an operand buffer, issues it to the MAC, and chains each partial sum back into the MAC's `pre_sum`. It returns the final sum through a valid/ready result port. It sits between the LSTM gate-level sequencer (start/result) and one MAC plus its weight/activation buffer.

---
 rtl/mac_seq_ctrl_if.sv | 49 ++++
 rtl/mac_seq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl_if.sv
// Bundle of job, operand-buffer, MAC and result signals around mac_seq_ctrl.
// result_valid/result_ready: a transfer happens on a rising edge where both are 1; once raised, result_valid and result hold until that edge.
interface mac_seq_ctrl_if #(
  parameter int W_BITWIDTH   = 8,
  parameter int IN_BITWIDTH  = W_BITWIDTH,
  parameter int OUT_BITWIDTH = 32,
  parameter int MAX_GROUPS   = 64,
  parameter int GW           = $clog2(MAX_GROUPS + 1)
);
  logic                      start;
  logic [GW-1:0]             n_groups;
  logic [OUT_BITWIDTH-1:0]   bias;
  logic                      busy;
  logic                      error;
  logic                      rd_en;
  logic [GW-1:0]             rd_addr;
  logic [3*W_BITWIDTH-1:0]   rd_w;
  logic [3*IN_BITWIDTH-1:0]  rd_x;
  logic                      mac_en;
  logic [W_BITWIDTH-1:0]     mac_weights_0;
  logic [W_BITWIDTH-1:0]     mac_weights_1;
  logic [W_BITWIDTH-1:0]     mac_weights_2;
  logic [IN_BITWIDTH-1:0]    mac_data_in_0;
  logic [IN_BITWIDTH-1:0]    mac_data_in_1;
  logic [IN_BITWIDTH-1:0]    mac_data_in_2;
  logic [OUT_BITWIDTH-1:0]   mac_pre_sum;
  logic                      mac_done;
  logic [OUT_BITWIDTH-1:0]   mac_out;
  logic [OUT_BITWIDTH-1:0]   result;
  logic                      result_valid;
  logic                      result_ready;
  logic [2:0]                dbg_state;

  modport slave (
    input  start, n_groups, bias, rd_w, rd_x, mac_done, mac_out, result_ready,
    output busy, error, rd_en, rd_addr, mac_en,
           mac_weights_0, mac_weights_1, mac_weights_2,
           mac_data_in_0, mac_data_in_1, mac_data_in_2,
           mac_pre_sum, result, result_valid, dbg_state
  );

  modport master (
    output start, n_groups, bias, rd_w, rd_x, mac_done, mac_out, result_ready,
    input  busy, error, rd_en, rd_addr, mac_en,
           mac_weights_0, mac_weights_1, mac_weights_2,
           mac_data_in_0, mac_data_in_1, mac_data_in_2,
           mac_pre_sum, result, result_valid, dbg_state
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Walks n_groups operand triplets through one bit-serial MAC, chaining each
// partial sum into the next pre_sum, and returns the final sum via valid/ready.
module mac_seq_ctrl #(
  parameter int W_BITWIDTH   = 8,
  parameter int IN_BITWIDTH  = W_BITWIDTH,
  parameter int OUT_BITWIDTH = 32,
  parameter int MAX_GROUPS   = 64,
  parameter int TIMEOUT      = 32,
  parameter int GW           = $clog2(MAX_GROUPS + 1)
) (
  input logic           clk,
  input logic           rst,
  mac_seq_ctrl_if.slave bus
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0]  MAX_N  = GW'(MAX_GROUPS);
  localparam logic [WDW-1:0] TO_CNT = WDW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT_HI, S_WAIT_LO, S_RESULT, S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           n_q, n_d;
  logic [GW-1:0]           g_q, g_d;
  logic [OUT_BITWIDTH-1:0] acc_q, acc_d;
  logic [WDW-1:0]          wd_q, wd_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;
  logic                    rd_en_q, rd_en_d;
  logic [GW-1:0]           rd_addr_q, rd_addr_d;
  logic                    mac_en_q, mac_en_d;
  logic [W_BITWIDTH-1:0]   mac_weights_q [3];
  logic [W_BITWIDTH-1:0]   mac_weights_d [3];
  logic [IN_BITWIDTH-1:0]  mac_data_in_q [3];
  logic [IN_BITWIDTH-1:0]  mac_data_in_d [3];
  logic [OUT_BITWIDTH-1:0] mac_pre_sum_q, mac_pre_sum_d;
  logic [OUT_BITWIDTH-1:0] result_q, result_d;
  logic                    result_valid_q, result_valid_d;

  logic [GW-1:0]           g_inc;
  logic [WDW-1:0]          wd_inc;
  logic                    to_err;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    g_d            = g_q;
    acc_d          = acc_q;
    wd_d           = wd_q;
    busy_d         = busy_q;
    error_d        = error_q;
    rd_en_d        = 1'b0;
    rd_addr_d      = rd_addr_q;
    mac_en_d       = 1'b0;
    mac_weights_d  = mac_weights_q;
    mac_data_in_d  = mac_data_in_q;
    mac_pre_sum_d  = mac_pre_sum_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    to_err         = 1'b0;
    g_inc          = g_q + 1'b1;
    wd_inc         = wd_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d     = (bus.n_groups > MAX_N) ? MAX_N : bus.n_groups;
          acc_d   = bus.bias;
          g_d     = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          if (bus.n_groups == '0) begin
            result_d       = bus.bias;
            result_valid_d = 1'b1;
            state_d        = S_RESULT;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            state_d   = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        // Buffer data is valid now, one cycle after the read strobe.
        for (int i = 0; i < 3; i++) begin
          mac_weights_d[i] = bus.rd_w[i*W_BITWIDTH +: W_BITWIDTH];
          mac_data_in_d[i] = bus.rd_x[i*IN_BITWIDTH +: IN_BITWIDTH];
        end
        mac_pre_sum_d = acc_q;
        mac_en_d      = 1'b1;
        wd_d          = '0;
        state_d       = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        wd_d = wd_inc;
        if (bus.mac_done) begin
          state_d = S_WAIT_LO;
        end else if (wd_inc == TO_CNT) begin
          to_err = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!bus.mac_done) begin
          acc_d = bus.mac_out;
          g_d   = g_inc;
          if (g_inc == n_q) begin
            result_d       = bus.mac_out;
            result_valid_d = 1'b1;
            state_d        = S_RESULT;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = g_inc;
            state_d   = S_FETCH;
          end
        end else begin
          wd_d = wd_inc;
          if (wd_inc == TO_CNT) to_err = 1'b1;
        end
      end
      S_RESULT: begin
        if (bus.result_ready) begin
          result_valid_d = 1'b0;
          busy_d         = 1'b0;
          state_d        = S_IDLE;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A stalled MAC abandons the job and quiets every MAC-facing lane.
    if (to_err) begin
      state_d       = S_ERR;
      error_d       = 1'b1;
      busy_d        = 1'b0;
      mac_en_d      = 1'b0;
      mac_weights_d = '{default: '0};
      mac_data_in_d = '{default: '0};
      mac_pre_sum_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      g_q            <= '0;
      acc_q          <= '0;
      wd_q           <= '0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      mac_en_q       <= 1'b0;
      mac_weights_q  <= '{default: '0};
      mac_data_in_q  <= '{default: '0};
      mac_pre_sum_q  <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      g_q            <= g_d;
      acc_q          <= acc_d;
      wd_q           <= wd_d;
      busy_q         <= busy_d;
      error_q        <= error_d;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      mac_en_q       <= mac_en_d;
      mac_weights_q  <= mac_weights_d;
      mac_data_in_q  <= mac_data_in_d;
      mac_pre_sum_q  <= mac_pre_sum_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.error         = error_q;
  assign bus.rd_en         = rd_en_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.mac_en        = mac_en_q;
  assign bus.mac_weights_0 = mac_weights_q[0];
  assign bus.mac_weights_1 = mac_weights_q[1];
  assign bus.mac_weights_2 = mac_weights_q[2];
  assign bus.mac_data_in_0 = mac_data_in_q[0];
  assign bus.mac_data_in_1 = mac_data_in_q[1];
  assign bus.mac_data_in_2 = mac_data_in_q[2];
  assign bus.mac_pre_sum   = mac_pre_sum_q;
  assign bus.result        = result_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.dbg_state     = state_q;
endmodule
